// File: rtl/pooling_pkg.sv
// Shared definitions for the 1-D pooling window path.
// Contents:
//   phase_e   - row phase of the window sequencer (head padding, body, tail padding)
//   out_len   - windows produced per padded row
//   cnt_w     - counter width helper, never below one bit
//   params_ok - elaboration sanity check on kernel, stride and padded length
package pooling_pkg;

   typedef enum logic [1:0] {
      PhHead = 2'd0,
      PhBody = 2'd1,
      PhTail = 2'd2
   } phase_e;

   function automatic int out_len(input int n, input int k, input int s, input int p);
      return (n + 2 * p - k) / s + 1;
   endfunction

   function automatic int cnt_w(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   function automatic bit params_ok(input int n, input int k, input int s, input int p);
      return (s >= 1) && (k >= 1) && (k <= n + 2 * p);
   endfunction

endpackage

// File: rtl/pool_window_buf.sv
// K-deep shift register holding the current pooling window.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   shift_i        - shift data_i in at the newest end
//   clr_i          - synchronous clear; when combined with shift_i only the new element survives
//   data_i         - incoming element
//   win_o          - window contents, [0] is the oldest element
module pool_window_buf #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             shift_i,
   input  logic             clr_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] win_o [Depth-1:0]
);

   logic [Width-1:0] buf_q [Depth-1:0];
   logic [Width-1:0] buf_d [Depth-1:0];

   always_comb begin
      buf_d = buf_q;
      if (shift_i) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            buf_d[i] = buf_q[i + 1];
         end
         buf_d[Depth-1] = data_i;
      end
      if (clr_i) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            buf_d[i] = '0;
         end
         if (!shift_i) begin
            buf_d[Depth-1] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         buf_q <= buf_d;
      end
   end

   assign win_o = buf_q;

endmodule

// File: rtl/avg_pool1d_window_ctrl.sv
// Streaming window sequencer for the 1-D average-pooling datapath. Accepts one element per
// handshake, inserts zero padding at both ends of each row, and presents KERNEL_SIZE-element
// windows at STRIDE spacing with row/tensor end markers.
// Optional feature: define AVG_POOL1D_WINDOW_CTRL_PAD_EN to compile in head/tail zero padding;
// without it PADDING must be 0.
// Ports:
//   clk, rst (async, active-low)
//   data_in_0 / _valid / _ready             - upstream element stream
//   data_out_0 [K-1:0] / _valid / _ready     - window out, [0] oldest
//   data_out_0_last_row / data_out_0_last    - last window of the row / of the tensor
module avg_pool1d_window_ctrl
   import pooling_pkg::*;
#(
   parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
   parameter int unsigned DATA_IN_0_PRECISION_1       = 3,
   parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
   parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
   parameter int unsigned KERNEL_SIZE                 = 2,
   parameter int unsigned STRIDE                      = 2,
   parameter int unsigned PADDING                     = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
   input  logic                             data_in_0_valid,
   output logic                             data_in_0_ready,
   output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_SIZE-1:0],
   output logic                             data_out_0_valid,
   input  logic                             data_out_0_ready,
   output logic                             data_out_0_last_row,
   output logic                             data_out_0_last
);

`ifdef AVG_POOL1D_WINDOW_CTRL_PAD_EN
   localparam int unsigned PadLen = PADDING;
`else
   localparam int unsigned PadLen = 0;
`endif
   localparam int unsigned NumElem = DATA_IN_0_TENSOR_SIZE_DIM_0;
   localparam int unsigned NumRows = DATA_IN_0_TENSOR_SIZE_DIM_1;
   localparam int unsigned RowLen  = NumElem + 2 * PadLen;
   localparam int unsigned OutLen  = out_len(NumElem, KERNEL_SIZE, STRIDE, PadLen);
   localparam int unsigned PosW    = cnt_w(RowLen + 1);
   localparam int unsigned StrW    = cnt_w(STRIDE);
   localparam int unsigned WinW    = cnt_w(OutLen + 1);
   localparam int unsigned RowW    = cnt_w(NumRows);
   localparam phase_e      PhReset = (PadLen > 0) ? PhHead : PhBody;

   if (!params_ok(NumElem, KERNEL_SIZE, STRIDE, PadLen)) begin : g_err_params
      $error("avg_pool1d_window_ctrl: need STRIDE >= 1 and 1 <= KERNEL_SIZE <= N + 2P");
   end
   if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_err_frac
      $error("avg_pool1d_window_ctrl: fractional bits exceed element width");
   end
`ifndef AVG_POOL1D_WINDOW_CTRL_PAD_EN
   if (PADDING != 0) begin : g_err_pad
      $error("avg_pool1d_window_ctrl: PADDING != 0 requires AVG_POOL1D_WINDOW_CTRL_PAD_EN");
   end
`endif

   phase_e                           phase_q, phase_d;
   logic   [PosW-1:0]                pos_q, pos_d;
   logic   [RowW-1:0]                row_q, row_d;
   logic   [StrW-1:0]                str_q, str_d;
   logic   [WinW-1:0]                win_q, win_d;
   logic                             ov_q, ov_d, lr_q, lr_d, la_q, la_d;
   logic                             shift_ok, do_shift, in_ready;
   logic   [DATA_IN_0_PRECISION_0-1:0] shift_data;
   logic                             row_end, last_row, fill_ok, aligned, last_win, win_done;

   // An un-taken window blocks all shifting so the presented window stays stable.
   assign shift_ok = !ov_q || data_out_0_ready;

   // FSM output process: handshake and shift source per phase. Reset gates ready low.
   always_comb begin
      in_ready   = 1'b0;
      do_shift   = 1'b0;
      shift_data = '0;
      if (rst && shift_ok) begin
         case (phase_q)
            PhBody: begin
               in_ready   = 1'b1;
               do_shift   = data_in_0_valid;
               shift_data = data_in_0;
            end
            default: do_shift = 1'b1;  // padding zero, one per cycle
         endcase
      end
   end

   assign row_end  = pos_q == PosW'(RowLen - 1);
   assign last_row = row_q == RowW'(NumRows - 1);
   assign fill_ok  = pos_q >= PosW'(KERNEL_SIZE - 1);
   // str_q counts down to the next aligned window start, replacing a modulo.
   assign aligned  = str_q == '0;
   assign last_win = win_q == WinW'(OutLen - 1);
   assign win_done = do_shift && fill_ok && aligned && (win_q < WinW'(OutLen));

   always_comb begin
      pos_d = pos_q;
      row_d = row_q;
      str_d = str_q;
      win_d = win_q;
      if (do_shift) begin
         if (row_end) begin
            pos_d = '0;
            str_d = '0;
            win_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            pos_d = pos_q + 1'b1;
            if (fill_ok) begin
               str_d = aligned ? StrW'(STRIDE - 1) : str_q - 1'b1;
            end
            if (win_done) begin
               win_d = win_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      ov_d = ov_q;
      lr_d = lr_q;
      la_d = la_q;
      if (shift_ok) begin
         ov_d = win_done;
         lr_d = win_done && last_win;
         la_d = win_done && last_win && last_row;
      end
   end

   // FSM next-state process: phase follows the position the next shift lands on.
   always_comb begin
      phase_d = phase_q;
`ifdef AVG_POOL1D_WINDOW_CTRL_PAD_EN
      if (do_shift) begin
         if (pos_d < PosW'(PadLen)) begin
            phase_d = PhHead;
         end else if (pos_d < PosW'(PadLen + NumElem)) begin
            phase_d = PhBody;
         end else begin
            phase_d = PhTail;
         end
      end
`else
      phase_d = PhBody;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= PhReset;
      end else begin
         phase_q <= phase_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos_q <= '0;
         row_q <= '0;
         str_q <= '0;
         win_q <= '0;
         ov_q  <= 1'b0;
         lr_q  <= 1'b0;
         la_q  <= 1'b0;
      end else begin
         pos_q <= pos_d;
         row_q <= row_d;
         str_q <= str_d;
         win_q <= win_d;
         ov_q  <= ov_d;
         lr_q  <= lr_d;
         la_q  <= la_d;
      end
   end

   // Clearing on the first shift of a row keeps the previous row out of the new windows.
   pool_window_buf #(
      .Width(DATA_IN_0_PRECISION_0),
      .Depth(KERNEL_SIZE)
   ) u_buf (
      .clk_i  (clk),
      .rst_ni (rst),
      .shift_i(do_shift),
      .clr_i  (do_shift && (pos_q == '0)),
      .data_i (shift_data),
      .win_o  (data_out_0)
   );

   assign data_in_0_ready     = in_ready;
   assign data_out_0_valid    = ov_q;
   assign data_out_0_last_row = lr_q;
   assign data_out_0_last     = la_q;

endmodule

// File: tb/tb_avg_pool1d_window_ctrl.sv
// Bench for avg_pool1d_window_ctrl: a vector table plus reset sequences on the default
// configuration, and randomized traffic on further configurations checked against a
// padded-row reference model.
module tb_avg_pool1d_window_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- Configuration A: N=8 K=2 S=2 P=0, table driven ----------------
   logic       a_rst_n = 1'b0;
   logic       a_iv, a_ir, a_ov, a_ordy, a_lr, a_la;
   logic [7:0] a_din;
   logic [7:0] a_dout [1:0];
   logic       a_done = 1'b0;

   avg_pool1d_window_ctrl #(
      .DATA_IN_0_PRECISION_0      (8),
      .DATA_IN_0_PRECISION_1      (3),
      .DATA_IN_0_TENSOR_SIZE_DIM_0(8),
      .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
      .KERNEL_SIZE                (2),
      .STRIDE                     (2),
      .PADDING                    (0)
   ) u_dut_a (
      .clk                (clk),
      .rst                (a_rst_n),
      .data_in_0          (a_din),
      .data_in_0_valid    (a_iv),
      .data_in_0_ready    (a_ir),
      .data_out_0         (a_dout),
      .data_out_0_valid   (a_ov),
      .data_out_0_ready   (a_ordy),
      .data_out_0_last_row(a_lr),
      .data_out_0_last    (a_la)
   );

   typedef struct {
      logic       iv;
      logic [7:0] din;
      logic       ordy;
      logic       ir;
      logic       ov;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       lr;
      logic       la;
   } vec_t;

   vec_t tbl [10];

   task automatic run_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         a_iv   = tbl[i].iv;
         a_din  = tbl[i].din;
         a_ordy = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("%s[%0d] in_ready", tag, i), a_ir, tbl[i].ir);
         chk($sformatf("%s[%0d] out_valid", tag, i), a_ov, tbl[i].ov);
         if (tbl[i].ov) begin
            chk($sformatf("%s[%0d] win[0]", tag, i), a_dout[0], tbl[i].d0);
            chk($sformatf("%s[%0d] win[1]", tag, i), a_dout[1], tbl[i].d1);
            chk($sformatf("%s[%0d] last_row", tag, i), a_lr, tbl[i].lr);
            chk($sformatf("%s[%0d] last", tag, i), a_la, tbl[i].la);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Inputs 1..8 streamed with ready high: windows {1,2},{3,4},{5,6},{7,8}, each one cycle
      // after its completing shift; the fourth carries last_row and last.
      tbl[0] = '{iv:1, din:1, ordy:1, ir:1, ov:0, d0:0, d1:0, lr:0, la:0};
      tbl[1] = '{iv:1, din:2, ordy:1, ir:1, ov:0, d0:0, d1:0, lr:0, la:0};
      tbl[2] = '{iv:1, din:3, ordy:1, ir:1, ov:1, d0:1, d1:2, lr:0, la:0};
      tbl[3] = '{iv:1, din:4, ordy:1, ir:1, ov:0, d0:0, d1:0, lr:0, la:0};
      tbl[4] = '{iv:1, din:5, ordy:1, ir:1, ov:1, d0:3, d1:4, lr:0, la:0};
      tbl[5] = '{iv:1, din:6, ordy:1, ir:1, ov:0, d0:0, d1:0, lr:0, la:0};
      tbl[6] = '{iv:1, din:7, ordy:1, ir:1, ov:1, d0:5, d1:6, lr:0, la:0};
      tbl[7] = '{iv:1, din:8, ordy:1, ir:1, ov:0, d0:0, d1:0, lr:0, la:0};
      tbl[8] = '{iv:0, din:0, ordy:1, ir:1, ov:1, d0:7, d1:8, lr:1, la:1};
      tbl[9] = '{iv:0, din:0, ordy:1, ir:1, ov:0, d0:0, d1:0, lr:0, la:0};

      a_iv   = 1'b1;
      a_din  = 8'hAA;
      a_ordy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", a_ir, 1'b0);
      chk("reset out_valid", a_ov, 1'b0);
      chk("reset last_row", a_lr, 1'b0);
      chk("reset last", a_la, 1'b0);
      chk("reset win", {a_dout[1], a_dout[0]}, 16'h0000);
      @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      run_table("row1");

      // Build a pending window {11,12} under back-pressure, then reset asynchronously.
      a_iv   = 1'b1;
      a_din  = 8'd11;
      a_ordy = 1'b0;
      @(posedge clk);
      #1;
      a_din = 8'd12;
      @(posedge clk);
      #1;
      a_din = 8'd13;
      chk("pending valid", a_ov, 1'b1);
      chk("pending win", {a_dout[1], a_dout[0]}, 16'h0C0B);
      chk("pending no accept", a_ir, 1'b0);
      #2;
      a_rst_n = 1'b0;
      #1;
      chk("async reset valid", a_ov, 1'b0);
      chk("async reset ready", a_ir, 1'b0);
      @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      run_table("after_rst");
      a_iv   = 1'b0;
      a_done = 1'b1;
   end

   // ---------------- Randomized configurations against a reference model ----------------
`ifdef AVG_POOL1D_WINDOW_CTRL_PAD_EN
   localparam int NCFG = 4;
`else
   localparam int NCFG = 3;
`endif
   localparam int CN [4] = '{7, 8, 4, 4};
   localparam int CK [4] = '{2, 3, 2, 3};
   localparam int CS [4] = '{2, 1, 2, 2};
   localparam int CP [4] = '{0, 0, 0, 1};
   localparam int CR [4] = '{1, 1, 2, 1};

   logic             rst_n = 1'b0;
   logic [NCFG-1:0]  cfg_done;

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int N    = CN[g];
      localparam int K    = CK[g];
      localparam int S    = CS[g];
      localparam int P    = CP[g];
      localparam int R    = CR[g];
      localparam int L    = N + 2 * P;
      localparam int OUT  = (L - K) / S + 1;
      localparam int ROWS = 5;
      localparam int TIN  = ROWS * N;
      localparam int TOUT = ROWS * OUT;

      logic       iv, ir, ov, ordy, lr, la;
      logic [7:0] din;
      logic [7:0] dout [K-1:0];
      logic       blk_done = 1'b0;

      avg_pool1d_window_ctrl #(
         .DATA_IN_0_PRECISION_0      (8),
         .DATA_IN_0_PRECISION_1      (3),
         .DATA_IN_0_TENSOR_SIZE_DIM_0(N),
         .DATA_IN_0_TENSOR_SIZE_DIM_1(R),
         .KERNEL_SIZE                (K),
         .STRIDE                     (S),
         .PADDING                    (P)
      ) u_dut (
         .clk                (clk),
         .rst                (rst_n),
         .data_in_0          (din),
         .data_in_0_valid    (iv),
         .data_in_0_ready    (ir),
         .data_out_0         (dout),
         .data_out_0_valid   (ov),
         .data_out_0_ready   (ordy),
         .data_out_0_last_row(lr),
         .data_out_0_last    (la)
      );

      assign cfg_done[g] = blk_done;

      logic [7:0]     stim   [TIN];
      logic [8*K-1:0] exp_w  [TOUT];
      logic           exp_lr [TOUT];
      logic           exp_la [TOUT];

      initial begin : run
         logic [7:0]     pad [L];
         logic [8*K-1:0] got, prev_w;
         logic           prev_stall, prev_lr, prev_la;
         int             n_in, n_out, last_cyc;
         iv   = 1'b0;
         ordy = 1'b0;
         din  = 8'h00;
         // Model: zero-pad each row, window w covers padded[w*S .. w*S+K-1].
         for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < L; j++) pad[j] = 8'h00;
            for (int j = 0; j < N; j++) begin
               stim[r*N+j] = 8'($urandom_range(1, 255));
               pad[P+j]    = stim[r*N+j];
            end
            for (int w = 0; w < OUT; w++) begin
               for (int k = 0; k < K; k++) exp_w[r*OUT+w][k*8+:8] = pad[w*S+k];
               exp_lr[r*OUT+w] = (w == OUT - 1);
               exp_la[r*OUT+w] = (w == OUT - 1) && (r % R == R - 1);
            end
         end
         wait (rst_n === 1'b1);
         @(posedge clk);
         #1;
         n_in       = 0;
         n_out      = 0;
         last_cyc   = 0;
         prev_stall = 1'b0;
         prev_w     = '0;
         prev_lr    = 1'b0;
         prev_la    = 1'b0;
         for (int cyc = 0; cyc < 4000 && n_out < TOUT; cyc++) begin
            // First row streams with no bubbles and no back-pressure; later traffic is random.
            iv   = (n_in < TIN) && ((n_in < N) || ($urandom_range(0, 3) != 0));
            din  = (n_in < TIN) ? stim[n_in] : 8'h00;
            ordy = (n_out < OUT) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            for (int k = 0; k < K; k++) got[k*8+:8] = dout[k];
            if (prev_stall) begin
               chk($sformatf("cfg%0d stall valid", g), ov, 1'b1);
               chk($sformatf("cfg%0d stall win", g), got, prev_w);
               chk($sformatf("cfg%0d stall last_row", g), lr, prev_lr);
               chk($sformatf("cfg%0d stall last", g), la, prev_la);
            end
            if (ov && !ordy) chk($sformatf("cfg%0d stall no accept", g), ir, 1'b0);
            if (iv && ir) n_in++;
            if (ov && ordy) begin
               chk($sformatf("cfg%0d win%0d data", g, n_out), got, exp_w[n_out]);
               chk($sformatf("cfg%0d win%0d last_row", g, n_out), lr, exp_lr[n_out]);
               chk($sformatf("cfg%0d win%0d last", g, n_out), la, exp_la[n_out]);
               if (n_out > 0 && n_out < OUT) begin
                  chk($sformatf("cfg%0d win%0d spacing", g, n_out), cyc - last_cyc, S);
               end
               last_cyc = cyc;
               n_out++;
            end
            prev_stall = ov && !ordy;
            prev_w     = got;
            prev_lr    = lr;
            prev_la    = la;
            @(posedge clk);
            #1;
         end
         chk($sformatf("cfg%0d windows seen", g), n_out, TOUT);
         iv       = 1'b0;
         ordy     = 1'b1;
         blk_done = 1'b1;
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 30000 && !((&cfg_done) && a_done); i++) @(posedge clk);
      chk("all blocks finished", {(&cfg_done), a_done}, 2'b11);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
